midi_rx: RTL and testbench
==========================

MIDI_RX -- requirements
Module: midi_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 31250, MIDI serial bit rate.
REQ-003 CLK  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 RST  input  1  reset: one clock; reset is synchronous and active-high.
REQ-005 MIDI_IN  input  1  asynchronous MIDI serial line, idle high, 8N1, LSB first.
REQ-006 MIDI_MSG  output  24  last complete channel message: {status, data1, data2}.
REQ-007 MIDI_MSG_RDY  output  1  one-cycle pulse; MIDI_MSG is valid in the same cycle.
REQ-008 RX_ERR  output  1  one-cycle pulse on a framing error.

Function
REQ-009 MIDI_IN SHALL pass through a 2-flop synchroniser before any use.
REQ-010 The bit period SHALL be DIV = CLK_HZ/BAUD cycles (integer division); the default is 1600.
REQ-011 The receiver SHALL have four states, IDLE/START/DATA/STOP, with these transitions:
- IDLE->START on a synchronised falling edge.
- START->DATA if the line is still low at DIV/2; otherwise START->IDLE (glitch, no error).
- DATA samples 8 bits, one every DIV cycles, LSB first, then goes to STOP.
- STOP samples the line DIV cycles after bit 7.
REQ-012 STOP sample high: the byte SHALL be valid for exactly one cycle, then the receiver returns to IDLE.
REQ-013 STOP sample low: RX_ERR SHALL pulse once, the byte SHALL be discarded, and the receiver SHALL wait in IDLE until the line is high before re-arming.
REQ-014 Parser, status bytes 80h-EFh: set the running status and clear the data count.
REQ-015 Data-byte count per status: 2 for 8xh, 9xh, Axh, Bxh and Exh; 1 for Cxh and Dxh.
REQ-016 Status F0h: enter sysex-skip. All data bytes are dropped until F7h or any other status byte arrives. Running status is cleared.
REQ-017 Status F1h-F7h: clear the running status; their data bytes SHALL be dropped.
REQ-018 Bytes F8h-FFh (real-time): ignored completely, with no change to running status, data count or sysex state.
REQ-019 A data byte (00h-7Fh) arriving with no running status SHALL be dropped.
REQ-020 When the data count for the running status is reached:
- MIDI_MSG SHALL load {status, d1, d2}, with d2 = 00h for 1-data-byte messages.
- MIDI_MSG_RDY SHALL pulse high for exactly 1 cycle.
- The data count SHALL clear, and the running status SHALL be kept.
REQ-021 Latency: MIDI_MSG_RDY SHALL assert on the cycle after the final byte's valid cycle.
REQ-022 MIDI_MSG SHALL hold its value between pulses.
REQ-023 A new status byte arriving mid-message SHALL abandon the partial message with no output.
REQ-024 MIDI_MSG_RDY SHALL never assert on two consecutive cycles.

Reset
REQ-025 While RST is high, all of the following SHALL hold, overriding any activity in that cycle:
- MIDI_MSG = 000000h, MIDI_MSG_RDY = 0, RX_ERR = 0.
- Receiver in IDLE with its bit counters at 0.
- Synchroniser flops at 1 (line idle).
- Running status cleared, data count 0, sysex-skip off.
REQ-026 A reset asserted mid-byte or mid-message SHALL discard that partial byte or message. After RST falls, reception SHALL restart only at the next falling edge.

Structure
REQ-027 A shared package SHALL hold:
- the status-class constants (NOTE_OFF 80h, NOTE_ON 90h, CTRL B0h, PROG C0h, SYSEX F0h, EOX F7h, RT_MIN F8h);
- the receiver state enumeration;
- a function that returns the data-byte count for a status byte.
REQ-028 The serial receiver SHALL be a sub-module named midi_uart_rx, with ports CLK, RST, RXD, BYTE[7:0], BYTE_VLD, FRAME_ERR. The parser lives in midi_rx.

Verification
REQ-029 Serial 90h 3Ch 64h -> one MIDI_MSG_RDY pulse with MIDI_MSG = 903C64h, 1 cycle after the stop sample of 64h.
REQ-030 Running status: following 90h 3Ch 64h, send 3Eh 40h -> second pulse with MIDI_MSG = 903E40h.
REQ-031 Sequence 80h F8h 3Ch FEh 00h -> a single pulse with MIDI_MSG = 803C00h; the real-time bytes have no effect.
REQ-032 C0h 05h, then 07h -> pulses with C00500h and then C00700h.
REQ-033 A byte whose stop bit is driven low -> one RX_ERR pulse and no MIDI_MSG_RDY; a following valid B0h 7Bh 00h -> B07B00h.
REQ-034 Both of these -> no output:
- F0h 7Eh 01h F7h, then 3Ch 40h;
- 90h 3Ch, then RST for 1 cycle, then 40h.
Each followed by 80h 3Ch 00h -> a single pulse with 803C00h.

Source files
------------

// File: rtl/midi_rx_pkg.sv
// Shared MIDI receiver definitions: status-class constants, receiver states and
// the per-status data-byte count.
package midi_rx_pkg;

    localparam logic [7:0] NOTE_OFF = 8'h80;
    localparam logic [7:0] NOTE_ON  = 8'h90;
    localparam logic [7:0] CTRL     = 8'hB0;
    localparam logic [7:0] PROG     = 8'hC0;
    localparam logic [7:0] SYSEX    = 8'hF0;
    localparam logic [7:0] EOX      = 8'hF7;
    localparam logic [7:0] RT_MIN   = 8'hF8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    // Number of data bytes that complete a channel message; 0 for non-channel status.
    function automatic logic [1:0] data_count(input logic [7:0] status);
        logic [1:0] n;
        case (status[7:4])
            NOTE_OFF[7:4], NOTE_ON[7:4], 4'hA, CTRL[7:4], 4'hE: n = 2'd2;
            PROG[7:4], 4'hD:                                     n = 2'd1;
            default:                                             n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial byte receiver with a 2-flop input synchroniser and mid-bit sampling.
module midi_uart_rx
    import midi_rx_pkg::*;
#(
    parameter int unsigned DIV = 1600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] BYTE,
    output logic       BYTE_VLD,
    output logic       FRAME_ERR
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic          rxd;

    assign rxd = sync_q[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], RXD};
            prev_q  <= sync_q[1];
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                // A falling edge needs the line high first, so a framing error
                // naturally waits for the line to return high before re-arming.
                if (prev_q && !rxd) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rxd ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rxd) vld_d = 1'b1;
                    else     err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign BYTE      = shift_q;
    assign BYTE_VLD  = vld_q;
    assign FRAME_ERR = err_q;

endmodule

// File: rtl/midi_rx.sv
// MIDI input: serial byte receiver plus channel-message parser with running status,
// real-time filtering and sysex skipping.
module midi_rx
    import midi_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 31250
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MIDI_IN,
    output logic [23:0] MIDI_MSG,
    output logic        MIDI_MSG_RDY,
    output logic        RX_ERR
);

    localparam int unsigned DIV = CLK_HZ / BAUD;

    logic [7:0]  rx_byte;
    logic        rx_vld;
    logic [7:0]  status_q, status_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  d1_q, d1_d;
    logic        sysex_q, sysex_d;
    logic [23:0] msg_q, msg_d;
    logic        rdy_q, rdy_d;
    logic [1:0]  need;

    midi_uart_rx #(
        .DIV(DIV)
    ) u_uart (
        .CLK      (CLK),
        .RST      (RST),
        .RXD      (MIDI_IN),
        .BYTE     (rx_byte),
        .BYTE_VLD (rx_vld),
        .FRAME_ERR(RX_ERR)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            status_q <= '0;
            cnt_q    <= '0;
            d1_q     <= '0;
            sysex_q  <= 1'b0;
            msg_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            cnt_q    <= cnt_d;
            d1_q     <= d1_d;
            sysex_q  <= sysex_d;
            msg_q    <= msg_d;
            rdy_q    <= rdy_d;
        end
    end

    assign need = data_count(status_q);

    always_comb begin
        status_d = status_q;
        cnt_d    = cnt_q;
        d1_d     = d1_q;
        sysex_d  = sysex_q;
        msg_d    = msg_q;
        rdy_d    = 1'b0;
        if (rx_vld) begin
            if (rx_byte >= RT_MIN) begin
                // Real-time bytes leave all parser state untouched.
            end else if (rx_byte == SYSEX) begin
                status_d = '0;
                cnt_d    = '0;
                sysex_d  = 1'b1;
            end else if (rx_byte > SYSEX && rx_byte <= EOX) begin
                status_d = '0;
                cnt_d    = '0;
                sysex_d  = 1'b0;
            end else if (rx_byte[7]) begin
                status_d = rx_byte;
                cnt_d    = '0;
                sysex_d  = 1'b0;
            end else if (!sysex_q && need != 2'd0) begin
                if (cnt_q + 2'd1 == need) begin
                    msg_d = (need == 2'd1) ? {status_q, rx_byte, 8'h00}
                                           : {status_q, d1_q, rx_byte};
                    rdy_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    d1_d  = rx_byte;
                    cnt_d = cnt_q + 2'd1;
                end
            end
        end
    end

    assign MIDI_MSG     = msg_q;
    assign MIDI_MSG_RDY = rdy_q;

endmodule

// File: tb/tb_midi_rx.sv
// Directed bench for midi_rx: serial frames are driven bit by bit and the parsed
// messages, pulse counts, framing errors and first-message latency are checked.
module tb_midi_rx;

    localparam int unsigned CLK_HZ = 160;
    localparam int unsigned BAUD   = 10;
    localparam int unsigned DIV    = CLK_HZ / BAUD;

    logic        CLK     = 1'b0;
    logic        RST     = 1'b1;
    logic        MIDI_IN = 1'b1;
    logic [23:0] MIDI_MSG;
    logic        MIDI_MSG_RDY;
    logic        RX_ERR;

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          pulses    = 0;
    int          errs      = 0;
    int          consec    = 0;
    int          last_cyc  = 0;
    int          start_cyc = 0;
    logic [23:0] last_msg  = '0;
    logic        prev_rdy  = 1'b0;
    int          p0;
    int          e0;

    midi_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .MIDI_IN     (MIDI_IN),
        .MIDI_MSG    (MIDI_MSG),
        .MIDI_MSG_RDY(MIDI_MSG_RDY),
        .RX_ERR      (RX_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (MIDI_MSG_RDY) begin
            pulses++;
            last_msg = MIDI_MSG;
            last_cyc = cyc;
            if (prev_rdy) consec++;
        end
        if (RX_ERR) errs++;
        prev_rdy = MIDI_MSG_RDY;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling clock edge; leaves the line idle for two bit times after the frame.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        logic [9:0] frame;
        frame     = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            MIDI_IN = frame[i];
            repeat (DIV) @(negedge CLK);
        end
        MIDI_IN = 1'b1;
        repeat (2 * DIV) @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_msg", 32'(MIDI_MSG), 32'h0);
        check("reset_rdy", 32'(MIDI_MSG_RDY), 32'h0);
        check("reset_err", 32'(RX_ERR), 32'h0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        p0 = pulses;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        check("note_on_count", 32'(pulses - p0), 32'd1);
        check("note_on_msg", 32'(last_msg), 32'h903C64);
        // 2 sync + 1 edge + DIV/2 + 9*DIV to the stop sample, then 1 parser cycle.
        check("note_on_latency", 32'(last_cyc - start_cyc), 32'(3 + DIV / 2 + 9 * DIV + 1));

        p0 = pulses;
        send_byte(8'h3E); send_byte(8'h40);
        check("running_count", 32'(pulses - p0), 32'd1);
        check("running_msg", 32'(last_msg), 32'h903E40);
        check("msg_hold", 32'(MIDI_MSG), 32'h903E40);

        p0 = pulses;
        send_byte(8'h80); send_byte(8'hF8); send_byte(8'h3C);
        send_byte(8'hFE); send_byte(8'h00);
        check("realtime_count", 32'(pulses - p0), 32'd1);
        check("realtime_msg", 32'(last_msg), 32'h803C00);

        p0 = pulses;
        send_byte(8'hC0); send_byte(8'h05);
        check("prog_count", 32'(pulses - p0), 32'd1);
        check("prog_msg", 32'(last_msg), 32'hC00500);
        send_byte(8'h07);
        check("prog_running_count", 32'(pulses - p0), 32'd2);
        check("prog_running_msg", 32'(last_msg), 32'hC00700);

        p0 = pulses;
        e0 = errs;
        send_byte(8'h55, 1'b0);
        check("frame_err_count", 32'(errs - e0), 32'd1);
        check("frame_err_no_msg", 32'(pulses - p0), 32'd0);
        send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);
        check("after_err_count", 32'(pulses - p0), 32'd1);
        check("after_err_msg", 32'(last_msg), 32'hB07B00);

        p0 = pulses;
        send_byte(8'hF0); send_byte(8'h7E); send_byte(8'h01); send_byte(8'hF7);
        send_byte(8'h3C); send_byte(8'h40);
        check("sysex_no_msg", 32'(pulses - p0), 32'd0);
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
        check("post_sysex_count", 32'(pulses - p0), 32'd1);
        check("post_sysex_msg", 32'(last_msg), 32'h803C00);

        p0 = pulses;
        send_byte(8'h90); send_byte(8'h3C);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("mid_reset_msg", 32'(MIDI_MSG), 32'h0);
        send_byte(8'h40);
        check("mid_reset_no_msg", 32'(pulses - p0), 32'd0);
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
        check("post_reset_count", 32'(pulses - p0), 32'd1);
        check("post_reset_msg", 32'(last_msg), 32'h803C00);

        check("no_back_to_back_rdy", 32'(consec), 32'd0);
        check("total_frame_errs", 32'(errs), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
